// File: rtl/nibble_serial_accumulator.sv
// Serial accumulator summing NUM_OPS 4-bit operands one nibble per clock through a 4-bit ripple adder.
// Optional saturation on overflow enabled by defining ACC_SAT_EN.

module ripple_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

module nibble_serial_accumulator #(
  parameter int unsigned ACC_W   = 8,
  parameter int unsigned NUM_OPS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int unsigned NIB   = ACC_W / 4;
  localparam int unsigned NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_OPS + 1);

  typedef enum logic [1:0] {StWaitOp, StAdd, StDone} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [3:0]         a_q, a_d;
  logic               carry_q, carry_d;
  logic [NIB_W-1:0]   nib_q, nib_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [3:0]         add_a, add_b, add_sum;
  logic               add_cout;

  // Operand only enters at nibble 0; higher nibbles just propagate the carry.
  assign add_a = acc_q[4*nib_q +: 4];
  assign add_b = (nib_q == '0) ? a_q : 4'h0;

  ripple_adder_4bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    carry_d = carry_q;
    nib_d   = nib_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StWaitOp: begin
        if (in_valid) begin
          a_d     = in_a;
          carry_d = in_cin;
          nib_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        carry_d = add_cout;
        nib_d   = nib_q + NIB_W'(1);
`ifdef ACC_SAT_EN
        // Once saturated, remaining operands are still sequenced but leave acc at all-ones.
        if (!ovf_q) begin
          acc_d[4*nib_q +: 4] = add_sum;
        end
`else
        acc_d[4*nib_q +: 4] = add_sum;
`endif
        if (nib_q == NIB_W'(NIB - 1)) begin
          if (add_cout) begin
            ovf_d = 1'b1;
`ifdef ACC_SAT_EN
            acc_d = '1;
`endif
          end
          count_d = count_q + CNT_W'(1);
          state_d = (count_q == CNT_W'(NUM_OPS - 1)) ? StDone : StWaitOp;
        end
      end
      StDone: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = StWaitOp;
        end
      end
      default: state_d = StWaitOp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWaitOp;
      acc_q   <= '0;
      a_q     <= 4'h0;
      carry_q <= 1'b0;
      nib_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      carry_q <= carry_d;
      nib_q   <= nib_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StWaitOp);
  assign out_valid = (state_q == StDone);
  assign result    = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// Directed bench for nibble_serial_accumulator: default 8-bit/4-op instance plus a 20-op instance
// that overflows; expectations follow ACC_SAT_EN when it is defined.

module tb_nibble_serial_accumulator;

  localparam int unsigned ACC_W = 8;
  localparam int unsigned NIB   = ACC_W / 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_cin, out_valid, out_ready, ovf;
  logic [3:0]       in_a;
  logic [ACC_W-1:0] result;

  logic             w_in_valid, w_in_ready, w_in_cin, w_out_valid, w_out_ready, w_ovf;
  logic [3:0]       w_in_a;
  logic [ACC_W-1:0] w_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nibble_serial_accumulator #(.ACC_W(ACC_W), .NUM_OPS(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf)
  );

  nibble_serial_accumulator #(.ACC_W(ACC_W), .NUM_OPS(20)) u_wide (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_a      (w_in_a),
    .in_cin    (w_in_cin),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .result    (w_result),
    .ovf       (w_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge of the first ADD cycle after the accept.
  task automatic send(input logic [3:0] a, input logic cin);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_cin   = cin;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] a, input logic cin);
    int n = 0;
    w_in_valid = 1'b1;
    w_in_a     = a;
    w_in_cin   = cin;
    while (!w_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("w_accept", 32'(w_in_ready), 32'd1);
    @(negedge clk);
    w_in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_a = 4'h0; in_cin = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = 4'h0; w_in_cin = 1'b0; w_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", 32'(result), 32'h0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_w_in_ready", 32'(w_in_ready), 32'd1);

    // 3+5+7+1 with exact out_valid timing
    send(4'd3, 1'b0); send(4'd5, 1'b0); send(4'd7, 1'b0); send(4'd1, 1'b0);
    check_eq("t1_ov_t1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_ov_t2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("t1_ov_t3", 32'(out_valid), 32'd1);
    check_eq("t1_result", 32'(result), 32'h10);
    check_eq("t1_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    check_eq("t1_ov_drop", 32'(out_valid), 32'd0);
    check_eq("t1_in_ready", 32'(in_ready), 32'd1);

    // Nibble-carry path: 4 x (15 + 1)
    for (int i = 0; i < 4; i++) send(4'd15, 1'b1);
    wait_valid("t2_valid");
    check_eq("t2_result", 32'(result), 32'h40);
    check_eq("t2_ovf", 32'(ovf), 32'd0);
    @(negedge clk);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd3, 1'b0);
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_result", 32'(result), 32'h0C);
      check_eq("bp_hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_in_ready", 32'(in_ready), 32'd1);
    check_eq("bp_cleared", 32'(result), 32'h0);
    check_eq("bp_ov_low", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) send(4'd1, 1'b0);
    wait_valid("bp2_valid");
    check_eq("bp2_result", 32'(result), 32'h04);
    @(negedge clk);

    // Idle gaps between operands; in_ready low for exactly NIB cycles after each accept
    for (int i = 0; i < 4; i++) begin
      repeat (i) @(negedge clk);
      send(4'd2, 1'b0);
      if (i < 3) begin
        for (int k = 0; k < int'(NIB); k++) begin
          check_eq("gap_busy", 32'(in_ready), 32'd0);
          @(negedge clk);
        end
        check_eq("gap_ready", 32'(in_ready), 32'd1);
      end
    end
    wait_valid("gap_valid");
    check_eq("gap_result", 32'(result), 32'h08);
    @(negedge clk);

    // Reset during ADD of the 3rd operand
    send(4'd4, 1'b0); send(4'd4, 1'b0); send(4'd4, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_ovf", 32'(ovf), 32'd0);
    check_eq("mid_rst_result", 32'(result), 32'h0);
    for (int i = 0; i < 4; i++) send(4'd4, 1'b0);
    wait_valid("mid_rst_valid");
    check_eq("mid_rst_frame", 32'(result), 32'h10);
    @(negedge clk);

    // 20 x (15 + 1) = 320 overflows 8 bits
    for (int i = 0; i < 20; i++) send_w(4'd15, 1'b1);
    begin
      int n = 0;
      while (!w_out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("wide_valid", 32'(w_out_valid), 32'd1);
`ifdef ACC_SAT_EN
    check_eq("wide_result", 32'(w_result), 32'hFF);
`else
    check_eq("wide_result", 32'(w_result), 32'h40);
`endif
    check_eq("wide_ovf", 32'(w_ovf), 32'd1);
    @(negedge clk);
    check_eq("wide_ovf_clr", 32'(w_ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nibble_serial_accumulator.md
Name: nibble_serial_accumulator

Overview:
- Downstream consumer and operand sequencer for the 4-bit ripple adder: accepts a stream of 4-bit operands (plus carry-in) over a valid/ready handshake.
- Sums NUM_OPS operands into an ACC_W-bit accumulator, one 4-bit nibble per clock, through a single internal ripple_adder_4bit instance.
- Presents the frame total on a valid/ready output, then clears and starts the next frame.

Parameters:
- ACC_W, 8: accumulator/result width. Multiple of 4, minimum 4. NIB = ACC_W/4 adder cycles per operand.
- NUM_OPS, 4: operands per frame. Minimum 1. Operand counter width is clog2(NUM_OPS+1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_a  input  4  unsigned operand.
- in_cin  input  1  carry-in, added at nibble 0 together with in_a.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  ACC_W  frame total.
- ovf  output  1  sticky: carry out of the top nibble occurred during this frame.

Behaviour:
- Reset: state WAIT_OP, acc=0, count=0, ovf=0, in_ready=1, out_valid=0, result=0. Reset wins over every other event, including mid-ADD and mid-DONE. A partial frame is discarded.
- States: WAIT_OP, ADD, DONE.
- WAIT_OP: in_ready=1.
  - When in_valid&in_ready, latch in_a/in_cin, set nib=0 and carry=in_cin, go to ADD.
  - in_valid low: hold.
- ADD: in_ready=0, one cycle per nibble.
  - acc[4*nib+:4] <= sum(acc nibble, nib==0 ? latched a : 0, carry); carry <= cout.
  - After nibble NIB-1: if cout=1, set ovf. Then count++.
  - If count reaches NUM_OPS, go to DONE. Otherwise return to WAIT_OP.
- Latency: operand accepted in cycle T occupies ADD cycles T+1..T+NIB.
  - in_ready is high again in T+NIB+1.
  - After the last operand, out_valid is high from cycle T+NIB+1.
  - Throughput: one operand per NIB+1 cycles.
- DONE: out_valid=1, in_ready=0.
  - result=acc and ovf are held stable while out_ready=0.
  - On out_ready=1: acc=0, count=0, ovf=0, go to WAIT_OP. in_ready=1 in the next cycle. No operand is accepted in the handshake cycle.
- result always reflects acc. Its value is only meaningful while out_valid=1.
- Arithmetic: unsigned, modulo 2^ACC_W, unless ACC_SAT_EN is defined.
- No combinational path from in_valid to in_ready or from out_ready to out_valid. All outputs are registered or decoded from state.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined:
  - On a top-nibble carry-out in the last ADD cycle, acc becomes all-ones and ovf=1.
  - For the rest of the frame, ADD cycles still run and are counted, but acc stays all-ones.
- Undefined: acc wraps modulo 2^ACC_W. ovf is still set as a sticky flag.

Test Plan:
- Defaults; after reset, feed 3,5,7,1 with cin=0 and out_ready=1 → result=0x10, ovf=0. out_valid is high exactly 3 cycles after the 4th accept and lasts 1 cycle.
- Defaults; feed 15,15,15,15 with cin=1 each → result=0x40, ovf=0, exercising the nibble-carry path.
- NUM_OPS=20; feed 20× (a=15, cin=1).
  - Without ACC_SAT_EN → result=0x40, ovf=1.
  - With ACC_SAT_EN → result=0xFF, ovf=1.
- Backpressure: finish a frame, hold out_ready=0 for 5 cycles → out_valid=1, result stable, in_ready=0. Raise out_ready → next cycle in_ready=1, acc cleared. The next frame 1,1,1,1 gives result=0x04.
- Input gaps: insert 0–3 idle cycles (in_valid=0) between operands 2,2,2,2 → result=0x08. in_ready stays low for exactly NIB cycles after each accept.
- Reset mid-operation: assert reset during ADD of the 3rd operand → next cycle in_ready=1, out_valid=0, ovf=0. A fresh frame 4,4,4,4 gives result=0x10.
